// File: rtl/io_input_unit.sv
// io_input_unit: console receive FIFO read by privileged GETC/RXCNT ops, popped only on retire
package io_input_pkg;
  typedef struct packed {
    logic [7:0] insn;
  } op_t;
  typedef enum logic {USER = 1'b0, SUPERVISOR = 1'b1} cpl_t;
  localparam logic [7:0] OPC_GETC  = 8'h30;
  localparam logic [7:0] OPC_RXCNT = 8'h31;
  function automatic logic [7:0] opc(input logic [7:0] insn);
    return insn;
  endfunction
endpackage

module io_input_unit
  import io_input_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  op_t                       op_spec_i,
  input  logic                      issue_i,
  input  logic                      flush_i,
  input  logic                      retire_i,
  input  cpl_t                      cpl_i,
  input  logic                      cpl_recompute_i,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic                      fault_o,
  input  logic                      rx_valid_i,
  input  logic [7:0]                rx_data_i,
  output logic                      rx_ready_o,
  output logic [$clog2(DEPTH):0]    rx_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {K_GETC, K_RXCNT, K_BAD} kind_t;
  state_t state;
  kind_t kind;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0] mem [DEPTH];
  logic push, pop, empty, retire_ok, good_retire;
  logic [7:0] head;
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign rx_ready_o = rst && (count != CW'(DEPTH));
  assign rx_count_o = count;
  assign push = rx_valid_i && rx_ready_o;
  assign retire_ok = (state == DONE) && retire_i && !flush_i && !cpl_recompute_i && (cpl_i == SUPERVISOR);
  assign good_retire = retire_ok && (kind != K_BAD);
  assign pop = retire_ok && (kind == K_GETC);
  assign done_o = (state == DONE) && !cpl_recompute_i;
  // byte storage; contents are only read when the FIFO is non-empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end
  // FIFO pointers and occupancy; a byte leaves only when its GETC retires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // op sequencing: capture the result on issue (or when a waiting GETC sees data), release on retire/flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      kind <= K_BAD;
      result_o <= '0;
      fault_o <= 1'b0;
    end else begin
      fault_o <= retire_i && !flush_i && !good_retire;
      if (flush_i) state <= IDLE;
      else case (state)
        IDLE: if (issue_i) begin
          kind <= opc(op_spec_i.insn) == OPC_GETC ? K_GETC : opc(op_spec_i.insn) == OPC_RXCNT ? K_RXCNT : K_BAD;
          if (opc(op_spec_i.insn) == OPC_GETC) begin
            if (!empty) result_o <= DATA_WIDTH'(head);
            state <= empty ? WAIT : DONE;
          end else begin
            result_o <= opc(op_spec_i.insn) == OPC_RXCNT ? DATA_WIDTH'(count) : '0;
            state <= DONE;
          end
        end
        WAIT: if (!empty) begin
          result_o <= DATA_WIDTH'(head);
          state <= DONE;
        end
        DONE: if (retire_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_input_unit.sv
// tb_io_input_unit: vector table, directed corner sequences and random traffic against a queue model
module tb_io_input_unit;
  import io_input_pkg::*;
  localparam int DW = 64;
  localparam int D = 8;
  logic clk = 0, rst = 0, issue = 0, flush = 0, retire = 0, rec = 0, rxv = 0;
  op_t op = '0;
  cpl_t cpl = SUPERVISOR;
  logic [7:0] rxd = 0;
  logic done, fault, ready;
  logic [DW-1:0] result;
  logic [3:0] cnt;
  int errors = 0, checks = 0;
  byte unsigned q[$];
  int ph = 0;
  logic [7:0] m_op = 0;
  logic [DW-1:0] m_res = 0;
  logic m_fault = 0;
  always #5 clk = ~clk;
  io_input_unit #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .op_spec_i(op), .issue_i(issue), .flush_i(flush), .retire_i(retire),
    .cpl_i(cpl), .cpl_recompute_i(rec), .done_o(done), .result_o(result), .fault_o(fault),
    .rx_valid_i(rxv), .rx_data_i(rxd), .rx_ready_o(ready), .rx_count_o(cnt)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // ph: 0 = no op, 1 = GETC waiting for a byte, 2 = result ready
  task automatic model_step;
    bit good = ph == 2 && !rec && cpl == SUPERVISOR && (m_op == OPC_GETC || m_op == OPC_RXCNT);
    bit pop = retire && !flush && good && m_op == OPC_GETC;
    bit push = rxv && q.size() < D;
    m_fault = retire && !flush && !good;
    if (flush) ph = 0;
    else if (ph == 0 && issue) begin
      m_op = op.insn;
      if (m_op == OPC_GETC) begin
        if (q.size() > 0) begin m_res = 64'(q[0]); ph = 2; end
        else ph = 1;
      end else begin
        m_res = (m_op == OPC_RXCNT) ? 64'(q.size()) : 64'd0;
        ph = 2;
      end
    end else if (ph == 1 && q.size() > 0) begin
      m_res = 64'(q[0]);
      ph = 2;
    end else if (ph == 2 && retire) ph = 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(rxd);
  endtask
  task automatic compare;
    check("done", done, 64'(ph == 2 && !rec));
    check("result", result, m_res);
    check("fault", fault, 64'(m_fault));
    check("count", cnt, 64'(q.size()));
    check("ready", ready, 64'(q.size() < D));
  endtask
  task automatic tick;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic do_reset;
    issue = 0; flush = 0; retire = 0; rec = 0; cpl = SUPERVISOR;
    rst = 0;
    #1;
    q.delete(); ph = 0; m_res = 0; m_fault = 0; m_op = 0;
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_fault", fault, 0);
    check("rst_ready", ready, 0);
    check("rst_count", cnt, 0);
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("rel_ready", ready, 1);
    check("rel_count", cnt, 0);
  endtask
  task automatic push_byte(input logic [7:0] b);
    rxv = 1; rxd = b; tick(); rxv = 0;
  endtask
  task automatic issue_op(input logic [7:0] o);
    op.insn = o; issue = 1; tick(); issue = 0;
  endtask
  task automatic retire_op(input cpl_t c);
    cpl = c; retire = 1; tick(); retire = 0; cpl = SUPERVISOR;
  endtask
  typedef struct {
    logic [7:0] opc;
    cpl_t c;
    int n;
    logic [63:0] res;
    logic flt;
    int cnt_after;
  } vec_t;
  vec_t tbl[6];
  int nxt;
  initial begin
    tbl[0] = '{OPC_GETC, SUPERVISOR, 2, 64'h10, 1'b0, 1};
    tbl[1] = '{OPC_RXCNT, SUPERVISOR, 3, 64'd3, 1'b0, 3};
    tbl[2] = '{OPC_GETC, USER, 1, 64'h10, 1'b1, 1};
    tbl[3] = '{8'h99, SUPERVISOR, 2, 64'd0, 1'b1, 2};
    tbl[4] = '{OPC_RXCNT, USER, 0, 64'd0, 1'b1, 0};
    tbl[5] = '{OPC_GETC, SUPERVISOR, 8, 64'h10, 1'b0, 7};
    rxv = 1; rxd = 8'hee;
    do_reset();
    rxv = 0;
    foreach (tbl[k]) begin
      do_reset();
      for (int i = 0; i < tbl[k].n; i++) push_byte(8'h10 + 8'(i));
      issue_op(tbl[k].opc);
      check("tbl_done", done, 1);
      check("tbl_result", result, tbl[k].res);
      retire_op(tbl[k].c);
      check("tbl_fault", fault, 64'(tbl[k].flt));
      check("tbl_count", cnt, 64'(tbl[k].cnt_after));
    end
    do_reset();
    push_byte(8'h41); push_byte(8'h42);
    issue_op(OPC_GETC);
    check("getc1_done", done, 1);
    check("getc1_result", result, 64'h41);
    retire_op(SUPERVISOR);
    check("getc1_count", cnt, 1);
    issue_op(OPC_GETC);
    check("getc2_result", result, 64'h42);
    retire_op(SUPERVISOR);
    issue_op(OPC_GETC);
    for (int i = 0; i < 5; i++) tick();
    check("wait_done", done, 0);
    push_byte(8'h7a);
    check("wait_push_done", done, 0);
    tick();
    check("wait_cap_done", done, 1);
    check("wait_cap_result", result, 64'h7a);
    retire_op(SUPERVISOR);
    check("wait_count", cnt, 0);
    push_byte(8'h55);
    issue_op(OPC_GETC);
    flush = 1; tick(); flush = 0;
    check("flush_count", cnt, 1);
    check("flush_done", done, 0);
    check("flush_fault", fault, 0);
    issue_op(OPC_GETC);
    retire_op(USER);
    check("user_fault", fault, 1);
    tick();
    check("user_fault_end", fault, 0);
    check("user_count", cnt, 1);
    retire = 1; tick(); retire = 0;
    check("idle_retire_fault", fault, 1);
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
    check("full_ready", ready, 0);
    rxv = 1; rxd = 8'h88;
    issue_op(OPC_GETC);
    check("stall_count", cnt, 8);
    check("full_result", result, 64'h80);
    retire_op(SUPERVISOR);
    check("pop_ready", ready, 1);
    check("pop_count", cnt, 7);
    tick();
    check("stalled_accept", cnt, 8);
    rxv = 0;
    nxt = 9;
    for (int k = 1; k < 16; k++) begin
      issue_op(OPC_GETC);
      check("drain_result", result, 64'h80 + 64'(k));
      retire_op(SUPERVISOR);
      if (nxt < 16) begin push_byte(8'h80 + 8'(nxt)); nxt++; end
    end
    check("drain_empty", cnt, 0);
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'h20 + 8'(i));
    rec = 1;
    issue_op(OPC_RXCNT);
    check("rec_done", done, 0);
    tick();
    check("rec_done_hold", done, 0);
    rec = 0;
    #1;
    check("rec_drop_done", done, 1);
    check("rec_result", result, 3);
    retire_op(SUPERVISOR);
    check("rxcnt_count", cnt, 3);
    check("rxcnt_fault", fault, 0);
    issue_op(OPC_RXCNT);
    rec = 1;
    retire_op(SUPERVISOR);
    rec = 0;
    check("rec_retire_fault", fault, 1);
    check("rec_retire_count", cnt, 3);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rxv = ($urandom % 2) == 0;
      rxd = 8'($urandom);
      issue = ($urandom % 4) == 0;
      case ($urandom % 8)
        0, 1, 2, 3: op.insn = OPC_GETC;
        4, 5, 6: op.insn = OPC_RXCNT;
        default: op.insn = 8'($urandom);
      endcase
      retire = (ph == 2) ? ($urandom % 3) == 0 : ($urandom % 25) == 0;
      flush = ($urandom % 20) == 0;
      rec = ($urandom % 10) == 0;
      cpl = (($urandom % 8) == 0) ? USER : SUPERVISOR;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_input_unit.md
# io_input_unit

Console input path of the CPU: the receive-side counterpart of the output I/O unit. Bytes from the host console channel are buffered in a small FIFO. Privileged `OPC_GETC` / `OPC_RXCNT` instructions read that FIFO through the execute/retire interface. A consumed byte leaves the FIFO only when its instruction retires, so a squashed speculative read never loses input.

## Interface
Parameters:
- `DATA_WIDTH`, 64: width of `result_o`.
- `DEPTH`, 8: receive FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1: sole clock; all logic on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `op_spec_i`  in  op_t: decoded op; `OPC(op_spec_i.insn)` selects the function; sampled on issue.
- `issue_i`  in  1: input op dispatched to this unit.
- `flush_i`  in  1: squash the in-flight op.
- `retire_i`  in  1: in-flight op retires.
- `cpl_i`  in  enum {USER, SUPERVISOR}: current privilege level.
- `cpl_recompute_i`  in  1: privilege level in flux; holds `done_o` low.
- `done_o`  out  1: result valid.
- `result_o`  out  DATA_WIDTH: op result.
- `fault_o`  out  1: one-cycle pulse on a permission or protocol fault.
- `rx_valid_i`  in  1: host byte valid.
- `rx_data_i`  in  8: host byte.
- `rx_ready_o`  out  1: FIFO can accept a byte.
- `rx_count_o`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - Push when `rx_valid_i && rx_ready_o`.
  - `rx_ready_o = rst && (count != DEPTH)`; there is no bypass when full.
  - Read/write pointers wrap modulo `DEPTH`.
  - Data is stored at the write pointer; the head is at the read pointer.
- **FSM states:** IDLE, WAIT, DONE.
  - IDLE, `issue_i`: latch the opcode.
    - `OPC_GETC`, FIFO non-empty: latch `result_o = {56'b0, head}` (zero-extended to `DATA_WIDTH`) and go to DONE.
    - `OPC_GETC`, FIFO empty: go to WAIT.
    - `OPC_RXCNT`: latch `result_o = count` (zero-extended) and go to DONE.
    - Any other opcode: latch `result_o = 0`, mark the op invalid, go to DONE.
  - WAIT: on the first cycle the FIFO is non-empty, latch the head and go to DONE.
  - DONE: wait for `retire_i` or `flush_i`.
- **`done_o`** = `(state == DONE) && !cpl_recompute_i`.
- **Retire in DONE**
  - `cpl_i == SUPERVISOR`, valid `OPC_GETC`: pop the head and go to IDLE.
  - `cpl_i == SUPERVISOR`, `OPC_RXCNT`: no pop; go to IDLE.
  - `cpl_i == USER`, or invalid op: pulse `fault_o`, no pop, go to IDLE.
- **Retire while `cpl_recompute_i` is high:** protocol fault. Pulse `fault_o`, no pop, go to IDLE.
- **`flush_i` in any state:** go to IDLE, no pop, no fault. `flush_i` takes priority over `retire_i` and `issue_i` in the same cycle.
- **Ignored events:**
  - `issue_i` outside IDLE is ignored; the pipeline guarantees at most one op in flight.
  - `retire_i` in IDLE or WAIT pulses `fault_o`; state is unchanged.
- **Push and pop together:** a push and a pop in the same cycle leave `count` unchanged and both pointers advance.

## Timing
- **Reset (`rst` low, asynchronous):**
  - State IDLE; FIFO empty; pointers 0.
  - `done_o = 0`, `result_o = 0`, `fault_o = 0`, `rx_ready_o = 0`, `rx_count_o = 0`.
  - Reset mid-op discards the op and all buffered bytes.
- **After reset release:** `rx_ready_o` rises combinationally.
- **Push:** a byte pushed at edge N is visible in `rx_count_o` after edge N.
- **`OPC_GETC`, FIFO non-empty:** `issue_i` at edge N gives `done_o` high after edge N (1-cycle latency).
- **`OPC_GETC` from WAIT:** a byte pushed at edge N is captured at edge N+1, so `done_o` goes high after edge N+1.
- **Pop:** occurs at the retire edge. `rx_count_o` drops after that edge; `rx_ready_o` reasserts combinationally if the FIFO was full.
- **`fault_o`:** high for exactly the cycle after the faulting edge.
- **`result_o`:** holds its value until the next capture.

## Test plan
- **Reset:** assert reset with `rx_valid_i=1` → all outputs 0. Release → `rx_ready_o=1`, `rx_count_o=0`.
- **GETC, buffered byte:** push 0x41, 0x42; SUPERVISOR `OPC_GETC` → `done_o` one cycle after issue, `result_o=0x41`. Retire → `rx_count_o=1`. Second GETC → `result_o=0x42`.
- **GETC on empty FIFO:** issue `OPC_GETC`, then push 0x7A five cycles later → `done_o` one cycle after the push, `result_o=0x7A`.
- **Flush and user retire:** flush a completed GETC on 0x55 → `rx_count_o` stays 1. Reissue and retire with `cpl_i=USER` → `fault_o` for 1 cycle, count still 1.
- **Full FIFO and wrap:** push `DEPTH`=8 bytes → `rx_ready_o=0`, 9th byte stalls. GETC and retire → ready reasserts and the stalled byte is accepted in the same cycle. Drain 16 bytes in order across the pointer wrap with no loss.
- **`cpl_recompute_i` and RXCNT:** hold `cpl_recompute_i` high during `OPC_RXCNT` with count=3 → `done_o` stays low. Drop it → `done_o=1`, `result_o=3`. Retire → count unchanged.
